// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe; slave is the datapath side, master the producer/consumer side.
interface addsub_pipe_if #(
   parameter int nIO = 16
);
   logic           in_valid;
   logic           in_ready;
   logic           sub;
   logic [nIO-1:0] a;
   logic [nIO-1:0] b;
   logic           out_valid;
   logic           out_ready;
   logic [nIO-1:0] s;
   logic           carry;
   logic           OV;
   logic           zero;
   logic           neg;

   modport slave (
      input  in_valid, sub, a, b, out_ready,
      output in_ready, out_valid, s, carry, OV, zero, neg
   );

   modport master (
      output in_valid, sub, a, b, out_ready,
      input  in_ready, out_valid, s, carry, OV, zero, neg
   );
endinterface

// File: rtl/addsub_pipe.sv
// Segmented add/sub, one SEG-bit carry segment per stage, latency NST = nIO/SEG; whole pipe stalls while out_valid && !out_ready.
// Define ADDSUB_SAT_EN to clamp signed-overflowed results to the signed extremes in the last stage.
module addsub_pipe #(
   parameter int nIO = 16,
   parameter int SEG = 8
) (
   input  logic         clk,
   input  logic         rst,
   addsub_pipe_if.slave bus
);
   localparam int NST = nIO / SEG;
   localparam int NRG = (NST > 1) ? NST - 1 : 1;

   logic           stall;
   logic           vld_r;
   logic           cy_r;
   logic           ov_r;
   logic           zero_r;
   logic           neg_r;
   logic [nIO-1:0] s_r;

   // Stage inputs: element 0 is the live bus, element k is the register of stage k-1.
   logic           vld_in [NST];
   logic           cy_in  [NST];
   logic           sub_in [NST];
   logic [nIO-1:0] a_in   [NST];
   logic [nIO-1:0] bb_in  [NST];
   logic [nIO-1:0] ps_in  [NST];

   logic           vld_q [NRG];
   logic           cy_q  [NRG];
   logic           sub_q [NRG];
   logic [nIO-1:0] a_q   [NRG];
   logic [nIO-1:0] bb_q  [NRG];
   logic [nIO-1:0] ps_q  [NRG];

   assign stall         = vld_r && !bus.out_ready;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = vld_r;
   assign bus.s         = s_r;
   assign bus.carry     = cy_r;
   assign bus.OV        = ov_r;
   assign bus.zero      = zero_r;
   assign bus.neg       = neg_r;

   for (genvar k = 0; k < NST; k++) begin : g_stg
      logic [SEG:0]   seg_sum;
      logic [nIO-1:0] ps_out;

      if (k == 0) begin : g_src
         assign vld_in[k] = bus.in_valid;
         assign cy_in[k]  = bus.sub;
         assign sub_in[k] = bus.sub;
         assign a_in[k]   = bus.a;
         assign bb_in[k]  = bus.b ^ {nIO{bus.sub}};
         assign ps_in[k]  = '0;
      end else begin : g_src
         assign vld_in[k] = vld_q[k-1];
         assign cy_in[k]  = cy_q[k-1];
         assign sub_in[k] = sub_q[k-1];
         assign a_in[k]   = a_q[k-1];
         assign bb_in[k]  = bb_q[k-1];
         assign ps_in[k]  = ps_q[k-1];
      end

      always_comb begin
         seg_sum = {1'b0, a_in[k][k*SEG +: SEG]} + {1'b0, bb_in[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, cy_in[k]};
         ps_out = ps_in[k];
         ps_out[k*SEG +: SEG] = seg_sum[SEG-1:0];
      end

      if (k < NST - 1) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               vld_q[k] <= 1'b0;
               cy_q[k]  <= 1'b0;
               sub_q[k] <= 1'b0;
               a_q[k]   <= '0;
               bb_q[k]  <= '0;
               ps_q[k]  <= '0;
            end else if (!stall) begin
               vld_q[k] <= vld_in[k];
               cy_q[k]  <= seg_sum[SEG];
               sub_q[k] <= sub_in[k];
               a_q[k]   <= a_in[k];
               bb_q[k]  <= bb_in[k];
               ps_q[k]  <= ps_out;
            end
         end
      end else begin : g_out
         logic           a_msb;
         logic           b_msb;
         logic           s_msb;
         logic           ov_nxt;
         logic [nIO-1:0] s_nxt;

         // Overflow is judged on the original b sign, recovered by undoing the inversion.
         always_comb begin
            a_msb  = a_in[k][nIO-1];
            b_msb  = bb_in[k][nIO-1] ^ sub_in[k];
            s_msb  = ps_out[nIO-1];
            ov_nxt = sub_in[k] ? ((a_msb != b_msb) && (s_msb != a_msb))
                               : ((a_msb == b_msb) && (s_msb != a_msb));
            s_nxt  = ps_out;
`ifdef ADDSUB_SAT_EN
            if (ov_nxt) begin
               s_nxt = a_msb ? {1'b1, {(nIO-1){1'b0}}} : {1'b0, {(nIO-1){1'b1}}};
            end
`else
`endif
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               vld_r  <= 1'b0;
               s_r    <= '0;
               cy_r   <= 1'b0;
               ov_r   <= 1'b0;
               zero_r <= 1'b0;
               neg_r  <= 1'b0;
            end else if (!stall) begin
               vld_r  <= vld_in[k];
               s_r    <= s_nxt;
               cy_r   <= seg_sum[SEG];
               ov_r   <= ov_nxt;
               zero_r <= (s_nxt == '0);
               neg_r  <= s_nxt[nIO-1];
            end
         end
      end
   end
endmodule

// File: tb/tb_addsub_pipe.sv
// Randomized + directed bench for addsub_pipe (nIO=16, SEG=8) against an integer-arithmetic reference model.
module tb_addsub_pipe;
   localparam int NST = 2;

   typedef struct packed {
      logic [15:0] s;
      logic        carry;
      logic        ov;
      logic        zero;
      logic        neg;
   } exp_t;

   typedef struct packed {
      logic        sub;
      logic [15:0] a;
      logic [15:0] b;
   } beat_t;

   typedef struct {
      exp_t e;
      int   cyc;
      int   stl;
   } track_t;

   logic   clk;
   logic   rst;
   int     n_tests;
   int     n_fail;
   int     cyc_cnt;
   int     stall_cnt;
   beat_t  beat_q[$];
   track_t exp_q[$];

   addsub_pipe_if #(.nIO(16)) bus ();

   addsub_pipe #(.nIO(16), .SEG(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: exact signed integer result decides overflow and clamping.
   function automatic exp_t model(input logic sub, input logic [15:0] a, input logic [15:0] b);
      exp_t        m;
      int          sa;
      int          sb;
      int          r;
      logic [16:0] full;
      sa = int'($signed(a));
      sb = int'($signed(b));
      r = sub ? (sa - sb) : (sa + sb);
      full = sub ? ({1'b0, a} + 17'h10000 - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      m.s = full[15:0];
      m.carry = full[16];
      m.ov = (r > 32767) || (r < -32768);
`ifdef ADDSUB_SAT_EN
      if (r > 32767) m.s = 16'h7FFF;
      else if (r < -32768) m.s = 16'h8000;
`endif
      m.zero = (m.s == 16'h0000);
      m.neg = m.s[15];
      return m;
   endfunction

   function automatic logic [15:0] rnd16();
      logic [15:0] c [5];
      c[0] = 16'h0000; c[1] = 16'h0001; c[2] = 16'h7FFF; c[3] = 16'h8000; c[4] = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
      return 16'($urandom_range(0, 65535));
   endfunction

   // Scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      cyc_cnt++;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               check("s", 32'(bus.s), 32'(exp_q[0].e.s));
               check("carry", 32'(bus.carry), 32'(exp_q[0].e.carry));
               check("OV", 32'(bus.OV), 32'(exp_q[0].e.ov));
               check("zero", 32'(bus.zero), 32'(exp_q[0].e.zero));
               check("neg", 32'(bus.neg), 32'(exp_q[0].e.neg));
               if (bus.out_ready) begin
                  check("latency", 32'(cyc_cnt - exp_q[0].cyc), 32'(NST + stall_cnt - exp_q[0].stl));
                  exp_q.delete(0);
               end
            end
         end
         check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
         if (bus.out_valid && !bus.out_ready) stall_cnt++;
         if (bus.in_valid && bus.in_ready) begin
            track_t t;
            t.e = model(bus.sub, bus.a, bus.b);
            t.cyc = cyc_cnt;
            t.stl = stall_cnt;
            exp_q.push_back(t);
         end
      end
   end

   // mode 0: always ready; 1: out_ready low for stream cycles 3..6; 2: random ready and bubbles.
   task automatic drive(input int mode);
      int k;
      k = 0;
      while (k < 3000) begin
         @(posedge clk);
         #1;
         if (beat_q.size() == 0 && exp_q.size() == 0 && !bus.out_valid) begin
            bus.in_valid = 1'b0;
            break;
         end
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = !(k >= 3 && k <= 6);
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (beat_q.size() != 0 && (mode != 2 || $urandom_range(0, 3) != 0)) begin
            bus.in_valid = 1'b1;
            bus.sub = beat_q[0].sub;
            bus.a = beat_q[0].a;
            bus.b = beat_q[0].b;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (bus.in_valid && bus.in_ready) beat_q.delete(0);
         k++;
      end
      check("drain_timeout", 32'(k < 3000), 32'd1);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail = 0;
      cyc_cnt = 0;
      stall_cnt = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.sub = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_s", 32'(bus.s), 32'd0);
      check("rst_carry", 32'(bus.carry), 32'd0);
      check("rst_OV", 32'(bus.OV), 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      check("rst_neg", 32'(bus.neg), 32'd0);

      // Directed vectors, back-to-back.
      beat_q.push_back({1'b0, 16'h00FF, 16'h0001});
      beat_q.push_back({1'b0, 16'h7FFF, 16'h0001});
      beat_q.push_back({1'b1, 16'h0000, 16'h0001});
      beat_q.push_back({1'b1, 16'h8000, 16'h0001});
      beat_q.push_back({1'b1, 16'h1234, 16'h1234});
      beat_q.push_back({1'b0, 16'h8000, 16'h8000});
      drive(0);

      // Backpressure: 4 beats with out_ready low mid-stream.
      for (int i = 0; i < 4; i++) beat_q.push_back({i[0], rnd16(), rnd16()});
      drive(1);

      // Reset with two beats in flight.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.sub = 1'b0;
      bus.a = 16'h1111;
      bus.b = 16'h2222;
      @(posedge clk);
      #1;
      bus.a = 16'h3333;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("flush_out_valid", 32'(bus.out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      beat_q.push_back({1'b1, 16'h0005, 16'h0007});
      drive(0);

      // Random traffic with random backpressure and bubbles.
      for (int i = 0; i < 300; i++) beat_q.push_back({1'($urandom_range(0, 1)), rnd16(), rnd16()});
      drive(2);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired tests=%0d", n_tests);
      $fatal(1);
   end
endmodule
